custom_wptr_full_burst: RTL and testbench

Write-side pointer and flag controller for the async FIFO family, generalised to multi-word (burst) writes.
- Accepts up to MAXW words per cycle on an all-or-nothing basis.
- Publishes the Gray-coded write pointer for synchronisation into the read domain.
- Derives fill level and free space from the read pointer, which arrives already synchronised as Gray.
- Adds a programmable almost-full threshold and a sticky overflow error.

---
 rtl/custom_wptr_full_burst_if.sv | 26 ++
 rtl/custom_wptr_full_burst.sv | 109 ++++++++++
 tb/tb_custom_wptr_full_burst.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/custom_wptr_full_burst_if.sv
// Burst write request/response bundle between a FIFO writer and the write-pointer controller.
// The writer owns the request; the controller answers with accept and the burst base address.
interface custom_wptr_full_burst_if #(
  parameter int ADDRSIZE = 4,
  parameter int MAXW     = 4,
  parameter int CNTW     = $clog2(MAXW + 1)
);
  logic                wen;
  logic [CNTW-1:0]     wr_num;
  logic                wr_accept;
  logic [ADDRSIZE-1:0] wr_addr;

  modport master (
    output wen,
    output wr_num,
    input  wr_accept,
    input  wr_addr
  );

  modport slave (
    input  wen,
    input  wr_num,
    output wr_accept,
    output wr_addr
  );
endinterface

// File: rtl/custom_wptr_full_burst.sv
// Write-side pointer and flag controller for the async FIFO, accepting all-or-nothing bursts
// of up to MAXW words, with almost-full threshold and a sticky overflow error.
//
// state | meaning
// INIT  | first cycle after reset; requests refused, pointers and flags hold reset values
// RUN   | normal operation; bursts accepted against live free space
module custom_wptr_full_burst #(
  parameter int ADDRSIZE = 4,
  parameter int MAXW     = 4,
  parameter int CNTW     = $clog2(MAXW + 1)
) (
  input  logic                  wclk_i,
  input  logic                  wrst_i,
  custom_wptr_full_burst_if.slave wr_bus,
  input  logic [ADDRSIZE:0]     rptr_sync2_wrclk,
  input  logic [ADDRSIZE:0]     afull_thresh,
  input  logic                  clr_err,
  output logic [ADDRSIZE:0]     wptr_g,
  output logic [ADDRSIZE:0]     wr_level,
  output logic [ADDRSIZE:0]     wr_space,
  output logic                  fifo_full,
  output logic                  fifo_almost_full,
  output logic                  overflow_err
);

  localparam int PW   = ADDRSIZE + 1;
  localparam int CMPW = (CNTW > PW) ? CNTW : PW;
  localparam logic [PW-1:0] DEPTH_P = PW'(1) << ADDRSIZE;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl;
  logic [PW-1:0] spc;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] lvl_next;
  logic [CMPW-1:0] num_ext;
  logic          num_ok;
  logic          accept;
  logic          req_bad;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    rbin    = gray2bin(rptr_sync2_wrclk);
    lvl     = wbin - rbin;
    spc     = DEPTH_P - lvl;
    num_ext = CMPW'(wr_bus.wr_num);
    num_ok  = (num_ext != '0) && (num_ext <= CMPW'(MAXW)) && (num_ext <= CMPW'(spc));
    // A request arriving with reset asserted is dropped, never acknowledged.
    accept  = (state == RUN) && !wrst_i && wr_bus.wen && num_ok;
    req_bad = (state == RUN) && wr_bus.wen && (wr_bus.wr_num != '0) && !accept;
    wbin_next = accept ? (wbin + PW'(wr_bus.wr_num)) : wbin;
    lvl_next  = wbin_next - rbin;
  end

  assign wr_bus.wr_accept = accept;
  assign wr_bus.wr_addr   = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      state            <= INIT;
      wbin             <= '0;
      wptr_g           <= '0;
      wr_level         <= '0;
      wr_space         <= DEPTH_P;
      fifo_full        <= 1'b1;
      fifo_almost_full <= 1'b1;
      overflow_err     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= RUN;
        end
        RUN: begin
          wbin             <= wbin_next;
          wptr_g           <= bin2gray(wbin_next);
          wr_level         <= lvl_next;
          wr_space         <= DEPTH_P - lvl_next;
          fifo_full        <= (lvl_next == DEPTH_P);
          // Threshold of zero keeps almost-full asserted since level is never negative.
          fifo_almost_full <= (lvl_next >= afull_thresh) || (lvl_next == DEPTH_P);
          if (req_bad) begin
            overflow_err <= 1'b1;
          end else if (clr_err) begin
            overflow_err <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_custom_wptr_full_burst.sv
// Directed table-driven bench for the burst write-pointer controller (ADDRSIZE=3, MAXW=4).
module tb_custom_wptr_full_burst;
  localparam int ADDRSIZE = 3;
  localparam int MAXW     = 4;
  localparam int CNTW     = 3;

  logic            wclk_i = 1'b0;
  logic            wrst_i;
  logic [3:0]      rptr_sync2_wrclk;
  logic [3:0]      afull_thresh;
  logic            clr_err;
  logic [3:0]      wptr_g;
  logic [3:0]      wr_level;
  logic [3:0]      wr_space;
  logic            fifo_full;
  logic            fifo_almost_full;
  logic            overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  custom_wptr_full_burst_if #(.ADDRSIZE(ADDRSIZE), .MAXW(MAXW), .CNTW(CNTW)) bus ();

  custom_wptr_full_burst #(.ADDRSIZE(ADDRSIZE), .MAXW(MAXW), .CNTW(CNTW)) dut (
    .wclk_i           (wclk_i),
    .wrst_i           (wrst_i),
    .wr_bus           (bus.slave),
    .rptr_sync2_wrclk (rptr_sync2_wrclk),
    .afull_thresh     (afull_thresh),
    .clr_err          (clr_err),
    .wptr_g           (wptr_g),
    .wr_level         (wr_level),
    .wr_space         (wr_space),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .overflow_err     (overflow_err)
  );

  always #5 wclk_i = ~wclk_i;

  typedef struct {
    logic       rst;
    logic       wen;
    logic [2:0] num;
    logic [3:0] rptr;
    logic [3:0] thr;
    logic       clr;
    logic       chk_acc;
    logic       acc;
    logic [2:0] addr;
    logic [3:0] g;
    logic [3:0] lvl;
    logic [3:0] spc;
    logic       full;
    logic       af;
    logic       err;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(int rst, int wen, int num, int rptr, int thr, int clr,
                              int chk_acc, int acc, int addr, int g, int lvl, int spc,
                              int full, int af, int err);
    vec_t v;
    v.rst = 1'(rst);   v.wen = 1'(wen);   v.num = 3'(num);
    v.rptr = 4'(rptr); v.thr = 4'(thr);   v.clr = 1'(clr);
    v.chk_acc = 1'(chk_acc); v.acc = 1'(acc); v.addr = 3'(addr);
    v.g = 4'(g); v.lvl = 4'(lvl); v.spc = 4'(spc);
    v.full = 1'(full); v.af = 1'(af); v.err = 1'(err);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    check("wr_addr",   idx, 32'(bus.wr_addr),      32'(v.addr));
    check("wptr_g",    idx, 32'(wptr_g),           32'(v.g));
    check("wr_level",  idx, 32'(wr_level),         32'(v.lvl));
    check("wr_space",  idx, 32'(wr_space),         32'(v.spc));
    check("full",      idx, 32'(fifo_full),        32'(v.full));
    check("afull",     idx, 32'(fifo_almost_full), 32'(v.af));
    check("ovf_err",   idx, 32'(overflow_err),     32'(v.err));
  endtask

  initial begin
    vec_t rst_v;
    // Columns: rst wen num rptr thr clr | chk_acc acc addr gray lvl spc full af err
    vecs[0]  = mk(0,1,4, 0,6,0, 1,0, 0, 0,0,8,1,1,0); // INIT: refused, no error
    vecs[1]  = mk(0,1,4, 0,6,0, 1,1, 4, 6,4,4,0,0,0);
    vecs[2]  = mk(0,1,4, 0,6,0, 1,1, 0,12,8,0,1,1,0); // full
    vecs[3]  = mk(0,1,1, 0,6,0, 1,0, 0,12,8,0,1,1,1); // overflow when full
    vecs[4]  = mk(0,1,2, 0,6,1, 1,0, 0,12,8,0,1,1,1); // set beats clear
    vecs[5]  = mk(0,0,0, 0,6,1, 1,0, 0,12,8,0,1,1,0); // clear alone
    vecs[6]  = mk(0,0,0, 3,6,0, 1,0, 0,12,6,2,0,1,0); // reader at 2 -> level 6
    vecs[7]  = mk(0,1,3, 3,6,0, 1,0, 0,12,6,2,0,1,1); // no partial acceptance
    vecs[8]  = mk(0,1,2, 3,6,1, 1,1, 2,15,8,0,1,1,0); // exact fit
    vecs[9]  = mk(0,0,0,15,6,0, 1,0, 2,15,0,8,0,0,0); // reader at 10 -> empty
    vecs[10] = mk(0,1,5,15,6,0, 1,0, 2,15,0,8,0,0,1); // wr_num > MAXW
    vecs[11] = mk(0,1,0,15,6,1, 1,0, 2,15,0,8,0,0,0); // wr_num=0 is a no-op
    vecs[12] = mk(0,1,4,15,5,0, 1,1, 6, 9,4,4,0,0,0);
    vecs[13] = mk(0,1,1,15,5,0, 1,1, 7, 8,5,3,0,1,0); // afull rises at threshold
    vecs[14] = mk(0,0,0,10,5,0, 1,0, 7, 8,3,5,0,0,0); // reader at 12 -> afull falls
    vecs[15] = mk(0,1,4,14,5,0, 1,1, 3, 2,8,0,1,1,0); // address and pointer wrap
    vecs[16] = mk(0,0,0, 2,0,0, 1,0, 3, 2,0,8,0,1,0); // threshold 0 -> afull held
    vecs[17] = mk(0,1,7, 2,6,0, 1,0, 3, 2,0,8,0,0,1);
    vecs[18] = mk(1,1,4, 2,6,0, 0,0, 0, 0,0,8,1,1,0); // reset mid-burst
    vecs[19] = mk(0,1,4, 0,6,0, 1,0, 0, 0,0,8,1,1,0); // back in INIT
    vecs[20] = mk(0,1,2, 0,6,0, 1,1, 2, 3,2,6,0,0,0);

    // Hand-written reset sequence: hold reset for two edges with a burst pending.
    wrst_i = 1'b1;
    bus.wen = 1'b1;
    bus.wr_num = 3'd4;
    rptr_sync2_wrclk = 4'd0;
    afull_thresh = 4'd6;
    clr_err = 1'b0;
    repeat (2) @(posedge wclk_i);
    #1;
    check("rst_accept", -1, 32'(bus.wr_accept), 32'd0);
    rst_v = mk(1,0,0,0,6,0, 0,0, 0,0,0,8,1,1,0);
    check_outputs(-1, rst_v);

    for (int i = 0; i < 21; i++) begin
      @(negedge wclk_i);
      wrst_i           = vecs[i].rst;
      bus.wen          = vecs[i].wen;
      bus.wr_num       = vecs[i].num;
      rptr_sync2_wrclk = vecs[i].rptr;
      afull_thresh     = vecs[i].thr;
      clr_err          = vecs[i].clr;
      #1;
      if (vecs[i].chk_acc) check("wr_accept", i, 32'(bus.wr_accept), 32'(vecs[i].acc));
      @(posedge wclk_i);
      #1;
      check_outputs(i, vecs[i]);
    end

    // Hand-written: idle RUN cycles with a moving reader keep acceptance on live space.
    @(negedge wclk_i);
    wrst_i = 1'b0; bus.wen = 1'b1; bus.wr_num = 3'd4; clr_err = 1'b0;
    rptr_sync2_wrclk = 4'd0;
    #1;
    check("seq_accept_a", 100, 32'(bus.wr_accept), 32'd1);    // level 2 -> 6
    @(posedge wclk_i);
    @(negedge wclk_i);
    bus.wr_num = 3'd3;
    rptr_sync2_wrclk = 4'b0011;                               // reader at 2: live level 4
    #1;
    check("seq_accept_b", 101, 32'(bus.wr_accept), 32'd1);
    @(posedge wclk_i);
    #1;
    check("seq_level", 101, 32'(wr_level), 32'd7);
    check("seq_gray",  101, 32'(wptr_g),   32'(4'd9 ^ 4'd4));  // wbin 9

    @(negedge wclk_i);
    bus.wen = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
